ptos_ciclo_sequencer: RTL and testbench



---
 rtl/ptos_ciclo_sequencer_pkg.sv | 32 +++
 rtl/ptos_seq_counter.sv | 84 ++++++++
 rtl/ptos_ciclo_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ptos_ciclo_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ptos_ciclo_sequencer_pkg.sv
// Shared definitions for the points-per-cycle run sequencer:
// register map, CTRL/STATUS/CLR bit positions, FSM state type, default widths.
package ptos_ciclo_sequencer_pkg;

  localparam int PTOS_W_DEF   = 16;
  localparam int CICLOS_W_DEF = 16;

  localparam logic [2:0] REG_PTOS    = 3'd0;
  localparam logic [2:0] REG_NCICLOS = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_CLR     = 3'd4;
  localparam logic [2:0] REG_IRQ_EN  = 3'd5;

  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_WAIT_TRIG = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_CFG_ERR = 2;

  localparam int CLR_DONE    = 0;
  localparam int CLR_CFG_ERR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/ptos_seq_counter.sv
// Point/cycle counters and registered framing strobes for one acquisition run.
// clr_i restarts a run from point 0 of cycle 0; tick_i is an accepted sample.
module ptos_seq_counter
  import ptos_ciclo_sequencer_pkg::*;
#(
  parameter int PTOS_W   = PTOS_W_DEF,
  parameter int CICLOS_W = CICLOS_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                tick_i,
  input  logic [PTOS_W-1:0]   ptos_i,
  input  logic [CICLOS_W-1:0] nciclos_i,
  output logic                final_o,
  output logic                point_valid_o,
  output logic [PTOS_W-1:0]   point_idx_o,
  output logic [CICLOS_W-1:0] cycle_idx_o,
  output logic                first_point_o,
  output logic                last_point_o,
  output logic                run_done_o
);

  logic [PTOS_W-1:0]   cnt_q, cnt_d;
  logic [CICLOS_W-1:0] cyc_q, cyc_d;
  logic                last_pt;
  logic                last_cyc;

  // Next counter values; cyc wraps naturally at 2^CICLOS_W in continuous mode.
  always_comb begin
    last_pt  = (cnt_q == ptos_i - PTOS_W'(1));
    last_cyc = (nciclos_i != '0) && (cyc_q == nciclos_i - CICLOS_W'(1));
    final_o  = last_pt && last_cyc;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    if (clr_i) begin
      cnt_d = '0;
      cyc_d = '0;
    end else if (tick_i) begin
      if (last_pt) begin
        cnt_d = '0;
        cyc_d = cyc_q + CICLOS_W'(1);
      end else begin
        cnt_d = cnt_q + PTOS_W'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end

  // Framing outputs describe the sample accepted on the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      point_valid_o <= 1'b0;
      first_point_o <= 1'b0;
      last_point_o  <= 1'b0;
      run_done_o    <= 1'b0;
      point_idx_o   <= '0;
      cycle_idx_o   <= '0;
    end else begin
      point_valid_o <= tick_i;
      first_point_o <= tick_i && (cnt_q == '0);
      last_point_o  <= tick_i && last_pt;
      run_done_o    <= tick_i && final_o;
      if (clr_i) begin
        point_idx_o <= '0;
        cycle_idx_o <= '0;
      end else if (tick_i) begin
        point_idx_o <= cnt_q;
        cycle_idx_o <= cyc_q;
      end
    end
  end

endmodule

// File: rtl/ptos_ciclo_sequencer.sv
// Avalon-MM run controller for the per-cycle acquisition datapath.
// Holds the register file and IDLE/ARM/RUN FSM; counting lives in ptos_seq_counter.
// Optional build macro PTOS_SEQ_IRQ_EN adds the irq output and IRQ_EN register.
module ptos_ciclo_sequencer
  import ptos_ciclo_sequencer_pkg::*;
#(
  parameter int PTOS_W   = PTOS_W_DEF,
  parameter int CICLOS_W = CICLOS_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic                trig,
  input  logic                sample_tick,
  output logic                point_valid,
  output logic [PTOS_W-1:0]   point_idx,
  output logic [CICLOS_W-1:0] cycle_idx,
  output logic                first_point,
  output logic                last_point,
  output logic                run_done,
  output logic                busy
`ifdef PTOS_SEQ_IRQ_EN
  , output logic              irq
`endif
);

  seq_state_e          state_q, state_d;
  logic [PTOS_W-1:0]   ptos_q;
  logic [CICLOS_W-1:0] nciclos_q;
  logic                wait_trig_q;
  logic                done_q;
  logic                cfg_err_q;
  logic                wr;
  logic                start_wr, abort_wr, clr_done_wr, clr_err_wr;
  logic                clr_cnt, run_tick, cfg_err_set, done_set;
  logic                cnt_final;
  logic [31:0]         cyc_ext;
  logic                unused_wd;

  assign wr          = chipselect && !write_n;
  assign start_wr    = wr && (address == REG_CTRL)  && writedata[CTRL_START];
  assign abort_wr    = wr && (address == REG_CTRL)  && writedata[CTRL_ABORT];
  assign clr_done_wr = wr && (address == REG_CLR)   && writedata[CLR_DONE];
  assign clr_err_wr  = wr && (address == REG_CLR)   && writedata[CLR_CFG_ERR];
  assign busy        = (state_q != IDLE);
  assign cyc_ext     = 32'(cycle_idx);
  assign unused_wd   = ^writedata;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus run control; abort wins over start and drops a same-cycle tick.
  always_comb begin
    state_d     = state_q;
    clr_cnt     = 1'b0;
    run_tick    = 1'b0;
    cfg_err_set = 1'b0;
    done_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_wr && !abort_wr) begin
          if (ptos_q == '0) begin
            cfg_err_set = 1'b1;
          end else begin
            clr_cnt = 1'b1;
            state_d = writedata[CTRL_WAIT_TRIG] ? ARM : RUN;
          end
        end
      end
      ARM: begin
        if (abort_wr)  state_d = IDLE;
        else if (trig) state_d = RUN;
      end
      RUN: begin
        if (abort_wr) begin
          state_d = IDLE;
        end else if (sample_tick) begin
          run_tick = 1'b1;
          if (cnt_final) begin
            done_set = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Configuration registers; frozen while busy so they also serve as the run shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptos_q      <= '0;
      nciclos_q   <= '0;
      wait_trig_q <= 1'b0;
    end else if (wr) begin
      if (address == REG_PTOS && !busy)    ptos_q      <= writedata[PTOS_W-1:0];
      if (address == REG_NCICLOS && !busy) nciclos_q   <= writedata[CICLOS_W-1:0];
      if (address == REG_CTRL)             wait_trig_q <= writedata[CTRL_WAIT_TRIG];
    end
  end

  // Sticky status flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      if (done_set)         done_q    <= 1'b1;
      else if (clr_done_wr) done_q    <= 1'b0;
      if (cfg_err_set)      cfg_err_q <= 1'b1;
      else if (clr_err_wr)  cfg_err_q <= 1'b0;
    end
  end

`ifdef PTOS_SEQ_IRQ_EN
  logic irq_en_q;

  // Interrupt enable register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                irq_en_q <= 1'b0;
    else if (wr && address == REG_IRQ_EN) irq_en_q <= writedata[0];
  end

  assign irq = done_q && irq_en_q;
`endif

  // Combinational read mux, zero-extended.
  always_comb begin
    readdata = '0;
    case (address)
      REG_PTOS:    readdata = 32'(ptos_q);
      REG_NCICLOS: readdata = 32'(nciclos_q);
      REG_CTRL:    readdata[CTRL_WAIT_TRIG] = wait_trig_q;
      REG_STATUS: begin
        readdata[STAT_BUSY]    = busy;
        readdata[STAT_DONE]    = done_q;
        readdata[STAT_CFG_ERR] = cfg_err_q;
        readdata[31:16]        = cyc_ext[15:0];
      end
`ifdef PTOS_SEQ_IRQ_EN
      REG_IRQ_EN:  readdata[0] = irq_en_q;
`endif
      default:     readdata = '0;
    endcase
  end

  ptos_seq_counter #(
    .PTOS_W   (PTOS_W),
    .CICLOS_W (CICLOS_W)
  ) u_counter (
    .clk           (clk),
    .reset         (reset),
    .clr_i         (clr_cnt),
    .tick_i        (run_tick),
    .ptos_i        (ptos_q),
    .nciclos_i     (nciclos_q),
    .final_o       (cnt_final),
    .point_valid_o (point_valid),
    .point_idx_o   (point_idx),
    .cycle_idx_o   (cycle_idx),
    .first_point_o (first_point),
    .last_point_o  (last_point),
    .run_done_o    (run_done)
  );

endmodule

// File: tb/tb_ptos_ciclo_sequencer.sv
// Directed bench for ptos_ciclo_sequencer: inputs driven after the falling edge,
// outputs sampled on the falling edge (or #1 later for the combinational read mux).
module tb_ptos_ciclo_sequencer;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        trig;
  logic        sample_tick;
  logic        point_valid;
  logic [15:0] point_idx;
  logic [15:0] cycle_idx;
  logic        first_point;
  logic        last_point;
  logic        run_done;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  ptos_ciclo_sequencer #(.PTOS_W(16), .CICLOS_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .trig        (trig),
    .sample_tick (sample_tick),
    .point_valid (point_valid),
    .point_idx   (point_idx),
    .cycle_idx   (cycle_idx),
    .first_point (first_point),
    .last_point  (last_point),
    .run_done    (run_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  // One accepted sample; checks the registered framing it produces.
  task automatic tick_chk(input string tag, input int idx, input int cyc,
                          input logic f, input logic l, input logic rd);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk({tag, "_frm"}, {28'b0, point_valid, first_point, last_point, run_done},
        {28'b0, 1'b1, f, l, rd});
    chk({tag, "_idx"}, {cycle_idx, point_idx}, {cyc[15:0], idx[15:0]});
  endtask

  // Tick that must not be accepted.
  task automatic tick_none(input string tag);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk(tag, {31'b0, point_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; trig = 1'b0; sample_tick = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_strobes", {27'b0, point_valid, first_point, last_point, run_done, busy}, 32'h0);
    chk("rst_idx", {cycle_idx, point_idx}, 32'h0);
    rd_chk("rst_ptos", 3'd0, 32'h0);
    rd_chk("rst_status", 3'd3, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: PTOS=4, NCICLOS=2, 8 ticks
    wr(3'd0, 32'd4);
    wr(3'd1, 32'd2);
    wr(3'd2, 32'h1);
    chk("t1_busy", {31'b0, busy}, 32'h1);
    for (int k = 0; k < 8; k++)
      tick_chk($sformatf("t1_pt%0d", k), k % 4, k / 4, (k % 4) == 0, (k % 4) == 3, k == 7);
    chk("t1_busy_end", {31'b0, busy}, 32'h0);
    rd_chk("t1_status", 3'd3, 32'h0001_0002);
    @(negedge clk);
    chk("t1_after", {30'b0, point_valid, run_done}, 32'h0);
    rd_chk("t1_other_addr", 3'd7, 32'h0);
    rd_chk("t1_reg5", 3'd5, 32'h0);
    wr(3'd4, 32'h1);
    rd_chk("t1_clr_done", 3'd3, 32'h0001_0000);

    // Test 2: start with PTOS=0
    wr(3'd0, 32'd0);
    wr(3'd2, 32'h1);
    rd_chk("t2_cfg_err", 3'd3, 32'h0001_0004);
    wr(3'd4, 32'h2);
    rd_chk("t2_clr_err", 3'd3, 32'h0001_0000);

    // Test 3: wait_trig, PTOS=3, NCICLOS=1
    wr(3'd0, 32'd3);
    wr(3'd1, 32'd1);
    wr(3'd2, 32'h5);
    rd_chk("t3_ctrl_rb", 3'd2, 32'h4);
    rd_chk("t3_armed", 3'd3, 32'h0000_0001);
    for (int k = 0; k < 5; k++) tick_none($sformatf("t3_arm_tick%0d", k));
    trig = 1'b1; sample_tick = 1'b1;
    @(negedge clk);
    trig = 1'b0; sample_tick = 1'b0;
    chk("t3_trig_tick", {30'b0, point_valid, busy}, 32'h1);
    for (int k = 0; k < 3; k++)
      tick_chk($sformatf("t3_pt%0d", k), k, 0, k == 0, k == 2, k == 2);
    rd_chk("t3_status", 3'd3, 32'h0000_0002);
    wr(3'd4, 32'h1);

    // Test 4: continuous PTOS=10, abort after 15 ticks
    wr(3'd0, 32'd10);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'h1);
    for (int k = 0; k < 15; k++)
      tick_chk($sformatf("t4_pt%0d", k), k % 10, k / 10, (k % 10) == 0, (k % 10) == 9, 1'b0);
    rd_chk("t4_pre_abort", 3'd3, 32'h0001_0001);
    sample_tick = 1'b1;
    wr(3'd2, 32'h3);
    sample_tick = 1'b0;
    chk("t4_abort", {29'b0, point_valid, run_done, busy}, 32'h0);
    rd_chk("t4_status", 3'd3, 32'h0001_0000);

    // Test 5: PTOS write while busy is ignored
    wr(3'd0, 32'd4);
    wr(3'd1, 32'd2);
    wr(3'd2, 32'h1);
    tick_chk("t5_pt0", 0, 0, 1'b1, 1'b0, 1'b0);
    wr(3'd0, 32'd7);
    rd_chk("t5_ptos_rb", 3'd0, 32'd4);
    for (int k = 1; k < 8; k++)
      tick_chk($sformatf("t5_pt%0d", k), k % 4, k / 4, (k % 4) == 0, (k % 4) == 3, k == 7);
    wr(3'd4, 32'h1);

    // PTOS=1: every point is both first and last
    wr(3'd0, 32'd1);
    wr(3'd2, 32'h1);
    tick_chk("t6_pt0", 0, 0, 1'b1, 1'b1, 1'b0);
    tick_chk("t6_pt1", 0, 1, 1'b1, 1'b1, 1'b1);
    wr(3'd4, 32'h1);

    // Reset during RUN at point 2
    wr(3'd0, 32'd4);
    wr(3'd2, 32'h1);
    for (int k = 0; k < 3; k++)
      tick_chk($sformatf("t7_pt%0d", k), k, 0, k == 0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t7_rst_strobes", {27'b0, point_valid, first_point, last_point, run_done, busy}, 32'h0);
    chk("t7_rst_idx", {cycle_idx, point_idx}, 32'h0);
    rd_chk("t7_rst_ptos", 3'd0, 32'h0);
    rd_chk("t7_rst_ncic", 3'd1, 32'h0);
    rd_chk("t7_rst_status", 3'd3, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("t7_post_rst", {29'b0, point_valid, run_done, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
